butterfly_32_in_buf: RTL and testbench

- Input row buffer that sits directly upstream of the 32-point forward-transform butterfly stage in the tq path.
- Accepts residual or transposed-intermediate samples 4 per beat under a valid/ready handshake and assembles one transform row of 4, 8, 16 or 32 samples.
- Presents each complete row as a 32-lane parallel bus, together with the butterfly enable, which is high only for 32-point rows.
- Two row banks in ping-pong, so the next row can fill while the current one is held by downstream.

---
 rtl/butterfly_32_in_buf.sv | 134 +++++++++++++
 tb/tb_butterfly_32_in_buf.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_32_in_buf.sv
// Ping-pong input row buffer ahead of the 32-point forward butterfly: gathers 4 samples/beat into 4..32-lane rows.
// Optional macro TQ_BUF_ROW_CNT_EN adds o_row_idx / o_blk_last row-within-block tracking.
module butterfly_32_in_buf #(
  parameter int DATA_W   = 27,
  parameter int LANES_IN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     o_in_ready,
  input  logic [1:0]               i_size,
  input  logic [LANES_IN*DATA_W-1:0] i_data,
  input  logic                     i_flush,
  output logic                     o_valid,
  input  logic                     i_out_ready,
  output logic [32*DATA_W-1:0]     o_data,
  output logic                     o_enable,
  output logic [1:0]               o_size
`ifdef TQ_BUF_ROW_CNT_EN
  ,
  output logic [4:0]               o_row_idx,
  output logic                     o_blk_last
`endif
);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;

  bank_state_t       state_q [2];
  bank_state_t       state_d [2];
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [2:0]        beat_q, beat_d;
  logic [1:0]        size_q [2];
  logic [DATA_W-1:0] mem_q [2][32];

  logic       accept;
  logic       out_fire;
  logic [1:0] row_size;
  logic       last_beat;

  // Ready depends only on registered bank state, never on i_out_ready.
  assign o_in_ready = (state_q[wr_bank_q] != FULL);
  assign o_valid    = (state_q[rd_bank_q] == FULL);
  assign accept     = i_valid && o_in_ready && !i_flush;
  assign out_fire   = o_valid && i_out_ready;
  assign row_size   = (beat_q == 3'd0) ? i_size : size_q[wr_bank_q];
  assign last_beat  = (beat_q == ((3'd1 << row_size) - 3'd1));

  always_comb begin
    for (int b = 0; b < 2; b++) state_d[b] = state_q[b];
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    beat_d    = beat_q;
    if (i_flush) begin
      if (state_q[wr_bank_q] == FILLING) state_d[wr_bank_q] = EMPTY;
      beat_d = 3'd0;
    end else if (accept) begin
      if (last_beat) begin
        state_d[wr_bank_q] = FULL;
        wr_bank_d          = ~wr_bank_q;
        beat_d             = 3'd0;
      end else begin
        state_d[wr_bank_q] = FILLING;
        beat_d             = beat_q + 3'd1;
      end
    end
    // A handshake only ever targets a FULL bank, so it never collides with the write bank.
    if (out_fire) begin
      state_d[rd_bank_q] = EMPTY;
      rd_bank_d          = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) state_q[b] <= EMPTY;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      beat_q    <= 3'd0;
    end else begin
      for (int b = 0; b < 2; b++) state_q[b] <= state_d[b];
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      beat_q    <= beat_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        size_q[b] <= 2'd0;
        for (int n = 0; n < 32; n++) mem_q[b][n] <= '0;
      end
    end else if (accept) begin
      if (beat_q == 3'd0) size_q[wr_bank_q] <= i_size;
      // Beat 0 also zeroes the lanes beyond this row so short rows present clean upper lanes.
      for (int n = 0; n < 32; n++) begin
        if (n / LANES_IN == int'(beat_q))
          mem_q[wr_bank_q][n] <= i_data[(n % LANES_IN)*DATA_W +: DATA_W];
        else if (beat_q == 3'd0 && n >= (LANES_IN << i_size))
          mem_q[wr_bank_q][n] <= '0;
      end
    end
  end

  always_comb begin
    for (int n = 0; n < 32; n++) o_data[n*DATA_W +: DATA_W] = mem_q[rd_bank_q][n];
  end

  assign o_size   = size_q[rd_bank_q];
  assign o_enable = o_valid && (size_q[rd_bank_q] == 2'd3);

`ifdef TQ_BUF_ROW_CNT_EN
  logic [4:0] row_cnt_q;
  logic [1:0] blk_size_q;
  logic [5:0] row_max;

  assign row_max    = (6'd4 << o_size) - 6'd1;
  // A size change since the last delivered row starts a new block.
  assign o_row_idx  = (o_size != blk_size_q) ? 5'd0 : row_cnt_q;
  assign o_blk_last = o_valid && (o_row_idx == row_max[4:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt_q  <= 5'd0;
      blk_size_q <= 2'd0;
    end else if (out_fire) begin
      blk_size_q <= o_size;
      row_cnt_q  <= (o_row_idx == row_max[4:0]) ? 5'd0 : o_row_idx + 5'd1;
    end
  end
`endif

endmodule

// File: tb/tb_butterfly_32_in_buf.sv
// Directed self-checking bench for butterfly_32_in_buf; define TQ_BUF_ROW_CNT_EN to also cover the row counter.
module tb_butterfly_32_in_buf;

  localparam int DATA_W = 27;
  localparam int ROW_W  = 32*DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid;
  logic              o_in_ready;
  logic [1:0]        i_size;
  logic [4*DATA_W-1:0] i_data;
  logic              i_flush;
  logic              o_valid;
  logic              i_out_ready;
  logic [ROW_W-1:0]  o_data;
  logic              o_enable;
  logic [1:0]        o_size;
`ifdef TQ_BUF_ROW_CNT_EN
  logic [4:0]        o_row_idx;
  logic              o_blk_last;
`endif

  int total = 0;
  int bad   = 0;

  butterfly_32_in_buf #(.DATA_W(DATA_W), .LANES_IN(4)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_in_ready(o_in_ready),
    .i_size(i_size), .i_data(i_data), .i_flush(i_flush), .o_valid(o_valid),
    .i_out_ready(i_out_ready), .o_data(o_data), .o_enable(o_enable), .o_size(o_size)
`ifdef TQ_BUF_ROW_CNT_EN
    , .o_row_idx(o_row_idx), .o_blk_last(o_blk_last)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // One beat, held until accepted; returns 1 time unit after the accepting edge.
  task automatic applyStimulus(input logic [1:0] size, input int v0, input int v1, input int v2, input int v3, input bit flush);
    int n;
    @(negedge clk);
    i_valid = 1'b1;
    i_size  = size;
    i_flush = flush;
    i_data  = {27'(v3), 27'(v2), 27'(v1), 27'(v0)};
    n = 0;
    while (!o_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) checkOutput("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    @(negedge clk);
    i_valid = 1'b0;
    i_flush = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  function automatic logic [ROW_W-1:0] rowExp(input int base, input int step, input int nl);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int n = 0; n < nl; n++) r[n*DATA_W +: DATA_W] = 27'(base + step*n);
    return r;
  endfunction

  task automatic sendRamp(input logic [1:0] size, input int base, input int beats);
    for (int j = 0; j < beats; j++)
      applyStimulus(size, base+4*j, base+4*j+1, base+4*j+2, base+4*j+3, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [ROW_W-1:0] exp_row;
    rst = 1'b1; i_valid = 1'b0; i_size = 2'd0; i_data = '0; i_flush = 1'b0; i_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", o_valid, 0);
    checkOutput("rst_in_ready", o_in_ready, 1);
    checkOutput("rst_data", o_data, 0);
    checkOutput("rst_enable", o_enable, 0);
    checkOutput("rst_size", o_size, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] 32pt ramp row");
    sendRamp(2'd3, 0, 7);
    checkOutput("t1_not_early", o_valid, 0);
    sendRamp(2'd3, 28, 1);
    checkOutput("t1_valid", o_valid, 1);
    checkOutput("t1_data", o_data, rowExp(0, 1, 32));
    checkOutput("t1_enable", o_enable, 1);
    checkOutput("t1_size", o_size, 3);
    idle(1);
    checkOutput("t1_one_cycle", o_valid, 0);

    $display("[TB] 4pt back-to-back");
    exp_row = '0;
    exp_row[0*DATA_W +: DATA_W] = 27'(-1);
    exp_row[1*DATA_W +: DATA_W] = 27'(2);
    exp_row[2*DATA_W +: DATA_W] = 27'(-3);
    exp_row[3*DATA_W +: DATA_W] = 27'(4);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(2'd0, -1, 2, -3, 4, 1'b0);
      checkOutput("t2_valid", o_valid, 1);
      checkOutput("t2_data", o_data, exp_row);
      checkOutput("t2_enable", o_enable, 0);
      checkOutput("t2_in_ready", o_in_ready, 1);
    end
    idle(1);
    checkOutput("t2_drained", o_valid, 0);

    $display("[TB] 8pt stall and drain");
    i_out_ready = 1'b0;
    sendRamp(2'd1, 100, 2);
    checkOutput("t3_in_ready_one_full", o_in_ready, 1);
    sendRamp(2'd1, 200, 2);
    checkOutput("t3_in_ready_low", o_in_ready, 0);
    checkOutput("t3_valid", o_valid, 1);
    checkOutput("t3_rowA", o_data, rowExp(100, 1, 8));
    idle(3);
    checkOutput("t3_rowA_stable", o_data, rowExp(100, 1, 8));
    checkOutput("t3_size", o_size, 1);
    i_out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t3_rowB_valid", o_valid, 1);
    checkOutput("t3_rowB", o_data, rowExp(200, 1, 8));
    checkOutput("t3_in_ready_back", o_in_ready, 1);
    @(posedge clk);
    #1;
    checkOutput("t3_drained", o_valid, 0);

    $display("[TB] 16pt flush");
    applyStimulus(2'd2, 55, 55, 55, 55, 1'b0);
    applyStimulus(2'd2, 55, 55, 55, 55, 1'b0);
    applyStimulus(2'd2, 55, 55, 55, 55, 1'b1);
    checkOutput("t4_flushed", o_valid, 0);
    for (int j = 0; j < 3; j++) applyStimulus(2'd2, 7, 7, 7, 7, 1'b0);
    checkOutput("t4_not_early", o_valid, 0);
    applyStimulus(2'd2, 7, 7, 7, 7, 1'b0);
    checkOutput("t4_valid", o_valid, 1);
    checkOutput("t4_data", o_data, rowExp(7, 0, 16));
    checkOutput("t4_size", o_size, 2);
    checkOutput("t4_enable", o_enable, 0);
    idle(1);
    checkOutput("t4_drained", o_valid, 0);

    $display("[TB] reset mid-row");
    i_out_ready = 1'b0;
    sendRamp(2'd3, 300, 8);
    sendRamp(2'd3, 400, 3);
    checkOutput("t5_pending", o_valid, 1);
    i_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_valid", o_valid, 0);
    checkOutput("t5_rst_in_ready", o_in_ready, 1);
    checkOutput("t5_rst_data", o_data, 0);
    @(negedge clk);
    rst = 1'b0;
    i_out_ready = 1'b1;
    sendRamp(2'd3, 500, 8);
    checkOutput("t5_valid", o_valid, 1);
    checkOutput("t5_data", o_data, rowExp(500, 1, 32));
    checkOutput("t5_enable", o_enable, 1);
    idle(1);

`ifdef TQ_BUF_ROW_CNT_EN
    $display("[TB] row counter");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 33; r++) begin
      sendRamp(2'd3, r, 8);
      checkOutput("t6_valid", o_valid, 1);
      checkOutput("t6_row_idx", o_row_idx, 5'(r % 32));
      checkOutput("t6_blk_last", o_blk_last, (r == 31));
    end
    idle(1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
